// File: rtl/bird_pkg.sv
// Shared address map, scanner code constants and status-word layout for the
// keypad path.
package bird_pkg;

    localparam logic [11:0] KEYPAD_ADDR      = 12'h710;
    localparam logic [11:0] KEYPAD_STAT_ADDR = 12'h711;
    localparam logic [11:0] DISPLAY1_ADDR    = 12'h730;
    localparam logic [11:0] MEM_END          = 12'h1ff;

    localparam logic [4:0]  KEY_NONE = 5'h10;

    localparam int ST_OVF     = 0;
    localparam int ST_RDY     = 2;
    localparam int ST_CNT_LSB = 8;

    // Status word: count in [11:8], ready in bit 2, overflow in bit 0.
    function automatic logic [15:0] status_word(input logic [3:0] cnt,
                                                input logic       not_empty,
                                                input logic       ovf);
        logic [15:0] w;
        w                   = '0;
        w[ST_CNT_LSB +: 4]  = cnt;
        w[ST_RDY]           = not_empty;
        w[ST_OVF]           = ovf;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; a pop on empty is ignored
// and a push on full is accepted only when a pop frees a slot the same cycle.
module sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [AW:0]      count_next
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/keypad_event_fifo.sv
// Queues debounced keypresses from the scanner and exposes them to the CPU as
// a memory-mapped data word (pops on first read cycle) and a status word.
module keypad_event_fifo
    import bird_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter logic [11:0] BASE_ADDR  = KEYPAD_ADDR,
    parameter logic [4:0]  EMPTY_CODE = KEY_NONE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_ready,
    input  logic [4:0]  key_code,
    output logic        key_ack,
    input  logic [11:0] addr,
    output logic [15:0] rd_data,
    output logic        sel,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          key_ready_d;
    logic          key_armed;
    logic          addr_hit_d;
    logic          stat_hit_d;
    logic          overflow;
    logic          data_hit;
    logic          stat_hit;
    logic          push_evt;
    logic          pop_evt;
    logic          stat_evt;
    logic          drop;
    logic [4:0]    head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    assign data_hit = (addr == BASE_ADDR);
    assign stat_hit = (addr == BASE_ADDR + 12'd1);
    assign sel      = data_hit || stat_hit;

    // key_armed blocks a ready level that is already high coming out of reset;
    // only a genuine low-to-high transition counts as a new key.
    assign push_evt = key_ready && !key_ready_d && key_armed;
    assign pop_evt  = data_hit && !addr_hit_d;
    assign stat_evt = stat_hit && !stat_hit_d;
    assign drop     = push_evt && full && !pop_evt;

    sync_fifo #(.WIDTH(5), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_evt),
        .pop        (pop_evt),
        .din        (key_code),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .count_next (count_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_ready_d <= 1'b0;
            key_armed   <= 1'b0;
            addr_hit_d  <= 1'b0;
            stat_hit_d  <= 1'b0;
            overflow    <= 1'b0;
            key_ack     <= 1'b0;
            irq         <= 1'b0;
        end else begin
            key_ready_d <= key_ready;
            key_armed   <= key_armed || !key_ready;
            addr_hit_d  <= data_hit;
            stat_hit_d  <= stat_hit;
            key_ack     <= push_evt;
            irq         <= (count_next != '0);
            // A fresh drop outranks the clear from a status read.
            if (drop)          overflow <= 1'b1;
            else if (stat_evt) overflow <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        if (data_hit)
            rd_data = {11'b0, empty ? EMPTY_CODE : head};
        else if (stat_hit)
            rd_data = status_word(4'(count), !empty, overflow);
    end

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Directed bench for keypad_event_fifo: a queue model checked every cycle plus
// hand-computed literal expectations along the test plan.
module tb_keypad_event_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_ready = 1'b0;
    logic [4:0]  key_code = '0;
    logic [11:0] addr = '0;
    logic        key_ack;
    logic [15:0] rd_data;
    logic        sel;
    logic        irq;

    int checks = 0;
    int errors = 0;

    keypad_event_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .key_ready (key_ready),
        .key_code  (key_code),
        .key_ack   (key_ack),
        .addr      (addr),
        .rd_data   (rd_data),
        .sel       (sel),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Model state: the queue of keys plus the few flags the rules need.
    logic [4:0] q[$];
    bit m_ovf, m_ack, m_krd, m_armed, m_ahd, m_shd;
    bit m_push, m_pop, m_stat;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            m_ovf = 0; m_ack = 0; m_krd = 0; m_armed = 0; m_ahd = 0; m_shd = 0;
        end else begin
            m_push = key_ready && !m_krd && m_armed;
            m_pop  = (addr == 12'h710) && !m_ahd;
            m_stat = (addr == 12'h711) && !m_shd;
            if (m_pop && q.size() > 0) void'(q.pop_front());
            if (m_push && q.size() == 8) m_ovf = 1;
            else begin
                if (m_push) q.push_back(key_code);
                if (m_stat) m_ovf = 0;
            end
            m_ack   = m_push;
            m_krd   = key_ready;
            m_armed = m_armed || !key_ready;
            m_ahd   = (addr == 12'h710);
            m_shd   = (addr == 12'h711);
        end
    end

    function automatic logic [15:0] exp_rd(input logic [11:0] a);
        int n = q.size();
        if (a == 12'h710) return (n == 0) ? 16'h0010 : {11'b0, q[0]};
        if (a == 12'h711) return 16'(n * 256 + (n != 0 ? 4 : 0) + (m_ovf ? 1 : 0));
        return 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("ack", 16'(key_ack), 16'(m_ack));
        chk("irq", 16'(irq), 16'(q.size() != 0));
        chk("sel", 16'(sel), 16'((addr == 12'h710) || (addr == 12'h711)));
        chk("rd_data", rd_data, exp_rd(addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [15:0] exp);
        #1;
        chk(name, rd_data, exp);
    endtask

    task automatic rd(input logic [11:0] a, input logic [15:0] exp, input string name);
        addr = a;
        lit(name, exp);
        tick();
        addr = '0;
        tick();
    endtask

    task automatic press(input logic [4:0] c);
        key_code  = c;
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        tick();
    endtask

    int acks;

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Reset state
        addr = 12'h710; lit("rst_data", 16'h0010);
        addr = 12'h711; lit("rst_stat", 16'h0000);
        chk("rst_irq", 16'(irq), 16'h0);
        addr = '0; tick();

        // Held ready gives one push and one ack
        key_code = 5'h05; key_ready = 1'b1;
        acks = 0;
        repeat (10) begin tick(); acks += int'(key_ack); end
        chk("ack_once", 16'(acks), 16'd1);
        key_ready = 1'b0; tick();
        rd(12'h711, 16'h0104, "one_stat");
        rd(12'h710, 16'h0005, "one_data");
        rd(12'h710, 16'h0010, "one_empty");

        // Overflow with nine presses
        for (int i = 1; i <= 9; i++) press(5'(i));
        rd(12'h711, 16'h0805, "ovf_stat");
        for (int i = 1; i <= 8; i++) rd(12'h710, 16'(i), "ovf_drain");
        rd(12'h710, 16'h0010, "ovf_empty");
        rd(12'h711, 16'h0000, "ovf_cleared");

        // Push and pop together on a full queue
        for (int i = 1; i <= 8; i++) press(5'(i));
        key_code = 5'h0A; key_ready = 1'b1; addr = 12'h710;
        lit("simul_head", 16'h0001);
        tick();
        key_ready = 1'b0; addr = '0; tick();
        rd(12'h711, 16'h0804, "simul_stat");
        for (int i = 2; i <= 8; i++) rd(12'h710, 16'(i), "simul_drain");
        rd(12'h710, 16'h000A, "simul_tail");

        // Held data address pops once
        press(5'h01); press(5'h02); press(5'h03);
        addr = 12'h710;
        repeat (5) tick();
        addr = '0; tick();
        rd(12'h711, 16'h0204, "hold_stat");
        rd(12'h710, 16'h0002, "hold_d2");
        rd(12'h710, 16'h0003, "hold_d3");
        rd(12'h710, 16'h0010, "hold_empty");

        // Reset in the middle of a ready pulse
        press(5'h04); press(5'h05); press(5'h06);
        key_code = 5'h07; key_ready = 1'b1;
        tick();
        rst = 1'b1; addr = 12'h711;
        #1;
        chk("mid_rst_ack", 16'(key_ack), 16'h0);
        chk("mid_rst_irq", 16'(irq), 16'h0);
        chk("mid_rst_stat", rd_data, 16'h0000);
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("no_repush", rd_data, 16'h0000);
            chk("no_reack", 16'(key_ack), 16'h0);
        end
        key_ready = 1'b0; tick();
        key_ready = 1'b1; tick();
        chk("repush_ack", 16'(key_ack), 16'h1);
        key_ready = 1'b0; addr = '0; tick();
        rd(12'h711, 16'h0104, "repush_stat");
        rd(12'h710, 16'h0007, "repush_data");

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
